// File: rtl/mips_pkg.sv
// Shared widths, reset default and fetch-side FSM encoding for the front end.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // RUN may issue, HOLD keeps a raised request until ready, STALL waits for a credit.
    typedef enum logic [1:0] {
        FETCH_RUN   = 2'd0,
        FETCH_HOLD  = 2'd1,
        FETCH_STALL = 2'd2
    } fetchState_t;

    // Instruction fetches are always word aligned; the two low bits are dropped.
    function automatic logic [ADDR_W-1:0] wordAlign(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO holding {instr, pc} entries between memory and decode.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wrData,
    output logic [WIDTH-1:0]           rdData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             doPush;
    logic             doPop;

    // Pop only real entries; a push into a full queue only lands if a pop frees the head slot.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign rdData = mem[head];

    // Storage array: written at the tail, never reset (occupancy tracking guards reads).
    always_ff @(posedge clk) begin
        if (doPush && !flush) begin
            mem[tail] <= wrData;
        end
    end

    // Head/tail pointers wrap naturally at DEPTH; flush discards everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                tail <= tail + PTR_W'(1);
            end
            if (doPop) begin
                head <= head + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word requests, queues responses for decode,
// and on a redirect flushes the queue while letting already-issued requests drain as stale.
module instr_prefetch_unit
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_pc_plus4
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 2;

    fetchState_t        state;
    fetchState_t        stateNext;
    logic [ADDR_W-1:0]  fetchPc;
    logic [ADDR_W-1:0]  rspPc;
    logic [ADDR_W-1:0]  holdAddr;
    logic [ADDR_W-1:0]  reqAddr;
    logic [ADDR_W-1:0]  redirectTarget;
    logic [ADDR_W-1:0]  headPc;
    logic [CNT_W-1:0]   liveCnt;
    logic [CNT_W-1:0]   staleCnt;
    logic [CNT_W-1:0]   fifoCount;
    logic [SUM_W-1:0]   inUse;
    logic               reqValid;
    logic               credit;
    logic               issueNew;
    logic               rspDrop;
    logic               rspKeep;
    logic               fifoPush;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [ENTRY_W-1:0] fifoWrData;
    logic [ENTRY_W-1:0] fifoRdData;

    assign redirectTarget = wordAlign(redirect_pc);

    // Every queued entry and every outstanding request (live or stale) holds one slot.
    assign inUse  = SUM_W'(fifoCount) + SUM_W'(liveCnt) + SUM_W'(staleCnt);
    assign credit = (inUse < SUM_W'(DEPTH));

    // Issue-side FSM outputs and next state; a HOLD request keeps its latched address.
    always_comb begin
        stateNext = state;
        reqValid  = 1'b0;
        reqAddr   = fetchPc;
        if (rst_n) begin
            case (state)
                FETCH_HOLD: begin
                    reqValid = 1'b1;
                    reqAddr  = holdAddr;
                    if (imem_req_ready) begin
                        stateNext = FETCH_RUN;
                    end
                end
                default: begin
                    reqValid = credit;
                    reqAddr  = fetchPc;
                    if (!credit) begin
                        stateNext = FETCH_STALL;
                    end else if (!imem_req_ready) begin
                        stateNext = FETCH_HOLD;
                    end else begin
                        stateNext = FETCH_RUN;
                    end
                end
            endcase
        end
    end

    assign imem_req_valid = reqValid;
    assign imem_req_addr  = reqAddr;

    // A request is counted outstanding the first cycle it is raised, fired or not.
    assign issueNew = reqValid && (state != FETCH_HOLD);
    assign rspDrop  = imem_rsp_valid && (staleCnt != '0);
    assign rspKeep  = imem_rsp_valid && (staleCnt == '0);
    assign fifoPush = rspKeep && !redirect_valid;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Fetch PC advances when a new request is raised; a held request keeps its own address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc  <= RESET_PC;
            holdAddr <= RESET_PC;
        end else begin
            if (issueNew && !imem_req_ready) begin
                holdAddr <= fetchPc;
            end
            if (redirect_valid) begin
                fetchPc <= redirectTarget;
            end else if (issueNew) begin
                fetchPc <= fetchPc + 32'd4;
            end
        end
    end

    // Response PC tracks the address of the next response that will be kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rspPc <= RESET_PC;
        end else if (redirect_valid) begin
            rspPc <= redirectTarget;
        end else if (rspKeep) begin
            rspPc <= rspPc + 32'd4;
        end
    end

    // Outstanding bookkeeping: a redirect turns everything in flight (including this cycle's
    // new request, minus this cycle's response) into stale responses to be dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            liveCnt  <= '0;
            staleCnt <= '0;
        end else if (redirect_valid) begin
            liveCnt  <= '0;
            staleCnt <= staleCnt + liveCnt + CNT_W'(issueNew) - CNT_W'(imem_rsp_valid);
        end else begin
            liveCnt  <= liveCnt + CNT_W'(issueNew) - CNT_W'(rspKeep);
            staleCnt <= staleCnt - CNT_W'(rspDrop);
        end
    end

    assign fifoWrData = {imem_rsp_data, rspPc};

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) uFifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (fifoPush),
        .pop    (instr_ready),
        .flush  (redirect_valid),
        .wrData (fifoWrData),
        .rdData (fifoRdData),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    // Decode-facing outputs read zero whenever the queue holds nothing.
    assign headPc         = fifoRdData[ADDR_W-1:0];
    assign instr_valid    = !fifoEmpty;
    assign instr_data     = fifoEmpty ? '0 : fifoRdData[ENTRY_W-1 -: INSTR_W];
    assign instr_pc       = fifoEmpty ? '0 : headPc;
    assign instr_pc_plus4 = fifoEmpty ? '0 : headPc + 32'd4;

    // Credits guarantee a free slot for every kept response; anything else is a memory bug.
    rspIntoFullQueue: assert property (@(posedge clk) disable iff (!rst_n)
        !(rspKeep && !redirect_valid && fifoFull && !instr_ready))
        else $error("instr_prefetch_unit: response arrived with the queue full");

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: fixed-latency memory model plus an expected-instruction queue.
module tb_instr_prefetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } expEntry_t;

    memReq_t     memQ[$];
    expEntry_t   expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          memLat = 1;
    int          fireCount = 0;
    int          popCount = 0;
    bit          ignoreFire = 0;
    bit          wasHeld = 0;
    logic [31:0] heldAddrPrev = '0;
    logic [31:0] nextAddr = '0;

    instr_prefetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return (a ^ 32'hDEAD_BEEF) + 32'h0101_0101;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory model: returns each accepted request after memLat cycles, in order.
    initial begin
        memReq_t r;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (memQ.size() > 0 && memQ[0].due <= cyc) begin
                r = memQ.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instrOf(r.addr);
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        expEntry_t e;
        if (rst_n) begin
            if (instr_valid && instr_ready) begin
                popCount++;
                checkEq("sb_has_expected", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkEq("sb_pc", instr_pc, e.pc);
                    checkEq("sb_data", instr_data, e.data);
                    checkEq("sb_pc_plus4", instr_pc_plus4, e.pc + 32'd4);
                end
            end
            if (wasHeld) begin
                checkEq("hold_valid", 32'(imem_req_valid), 32'd1);
                checkEq("hold_addr", imem_req_addr, heldAddrPrev);
            end
            if (imem_req_valid && imem_req_ready) begin
                fireCount++;
                memQ.push_back('{addr: imem_req_addr, due: cyc + memLat});
                if (ignoreFire) begin
                    ignoreFire = 0;
                end else begin
                    checkEq("req_addr", imem_req_addr, nextAddr);
                    nextAddr = nextAddr + 32'd4;
                    if (!redirect_valid) begin
                        expQ.push_back('{data: instrOf(imem_req_addr), pc: imem_req_addr});
                    end
                end
            end
            if (redirect_valid) begin
                expQ.delete();
                nextAddr = {redirect_pc[31:2], 2'b00};
                if (imem_req_valid && !imem_req_ready) begin
                    ignoreFire = 1;
                end
            end
            wasHeld      = imem_req_valid && !imem_req_ready;
            heldAddrPrev = imem_req_addr;
        end
    end

    task automatic doReset();
        rst_n = 1'b0;
        memQ.delete();
        expQ.delete();
        fireCount  = 0;
        popCount   = 0;
        ignoreFire = 0;
        wasHeld    = 0;
        nextAddr   = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkEq("rst_req_valid", 32'(imem_req_valid), 32'd0);
            checkEq("rst_instr_valid", 32'(instr_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic waitFireCheck(input string tag, input logic [31:0] expAddr);
        bit found = 0;
        logic [31:0] a = '0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                found = 1;
                a = imem_req_addr;
            end
        end
        checkEq({tag, "_seen"}, 32'(found), 32'd1);
        if (found) checkEq(tag, a, expAddr);
    endtask

    task automatic waitInstrCheck(input string tag, input logic [31:0] expPc,
                                  input logic [31:0] expPlus4);
        bit found = 0;
        logic [31:0] p = '0;
        logic [31:0] p4 = '0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                found = 1;
                p  = instr_pc;
                p4 = instr_pc_plus4;
            end
        end
        checkEq({tag, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            checkEq({tag, "_pc"}, p, expPc);
            checkEq({tag, "_pc_plus4"}, p4, expPlus4);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int f0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        memLat         = 1;

        // Reset and first request.
        doReset();
        @(negedge clk);
        checkEq("first_req_valid", 32'(imem_req_valid), 32'd1);
        checkEq("first_req_addr", imem_req_addr, 32'h0);
        checkEq("first_instr_valid", 32'(instr_valid), 32'd0);

        // Steady streaming at latency 1: one instruction per cycle.
        repeat (10) @(posedge clk);
        p0 = popCount;
        repeat (10) @(posedge clk);
        checkEq("steady_rate", 32'(popCount - p0), 32'd10);

        // Decode stalled: credits cap issue at the queue depth.
        instr_ready = 1'b0;
        doReset();
        f0 = fireCount;
        repeat (15) @(posedge clk);
        checkEq("credit_fires", 32'(fireCount - f0), 32'd4);
        @(negedge clk);
        checkEq("credit_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        waitFireCheck("resume_addr", 32'h10);
        repeat (10) @(posedge clk);

        // Latency 3 redirect with requests in flight.
        memLat = 3;
        doReset();
        repeat (6) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        checkEq("flush_instr_valid", 32'(instr_valid), 32'd0);
        waitInstrCheck("redir_first", 32'h100, 32'h104);
        repeat (12) @(posedge clk);

        // Redirect while a request is held by memory backpressure.
        memLat = 1;
        doReset();
        for (int i = 0; i < 20 && fireCount < 2; i++) @(posedge clk);
        checkEq("hold_setup_fires", 32'(fireCount), 32'd2);
        #1;
        imem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkEq("held_valid", 32'(imem_req_valid), 32'd1);
        checkEq("held_addr", imem_req_addr, 32'h8);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkEq("held_addr_after_redir", imem_req_addr, 32'h8);
        @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        waitFireCheck("held_fire", 32'h8);
        waitFireCheck("post_redir_fire", 32'h40);
        waitInstrCheck("post_redir_instr", 32'h40, 32'h44);
        repeat (10) @(posedge clk);

        // Redirect to the top of the address space and wrap.
        doReset();
        repeat (4) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        waitFireCheck("wrap_fire_top", 32'hFFFF_FFFC);
        waitFireCheck("wrap_fire_zero", 32'h0);
        waitInstrCheck("wrap_top", 32'hFFFF_FFFC, 32'h0);
        waitInstrCheck("wrap_zero", 32'h0, 32'h4);
        repeat (8) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
